// File: rtl/pe_requant.sv
// Requantizer behind the PE array: bias add, rounding shift, saturate, output FIFO.
// Optional build macro PE_REQUANT_RELU_EN clamps negative results to zero.
module pe_requant #(
  parameter int PE_OUT_WIDTH = 24,
  parameter int BIAS_WIDTH   = 16,
  parameter int SHIFT_WIDTH  = 5,
  parameter int OUT_WIDTH    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_load,
  input  logic [BIAS_WIDTH-1:0]         bias_in,
  input  logic [SHIFT_WIDTH-1:0]        shift_in,
  input  logic                          acc_valid,
  input  logic [PE_OUT_WIDTH-1:0]       pe_y,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          drop_err
);

  localparam int SW = PE_OUT_WIDTH + 1;
  localparam int RW = PE_OUT_WIDTH + 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic signed [RW-1:0] LMAX = RW'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] LMIN = ~LMAX;

  logic [BIAS_WIDTH-1:0]  r_bias;
  logic [SHIFT_WIDTH-1:0] r_shift;

  logic                   r_s1_valid;
  logic signed [SW-1:0]   r_s1_sum;
  logic [SHIFT_WIDTH-1:0] r_s1_shift;
  logic                   r_s2_valid;
  logic signed [RW-1:0]   r_s2_r;
  logic                   r_s3_valid;
  logic [OUT_WIDTH-1:0]   r_s3_data;

  logic signed [SW-1:0]   w_sum;
  logic [SHIFT_WIDTH-1:0] w_s;
  logic [RW-1:0]          w_rnd;
  logic signed [RW-1:0]   w_ext;
  logic signed [RW-1:0]   w_add;
  logic signed [RW-1:0]   w_r;
  logic signed [RW-1:0]   w_clip;
  logic [OUT_WIDTH-1:0]   w_sat;

  // Sum is one bit wider than pe_y, so it can never overflow.
  assign w_sum = {pe_y[PE_OUT_WIDTH-1], pe_y}
               + {{(SW-BIAS_WIDTH){r_bias[BIAS_WIDTH-1]}}, r_bias};

  assign w_s = (r_s1_shift > SHIFT_WIDTH'(PE_OUT_WIDTH))
             ? SHIFT_WIDTH'(PE_OUT_WIDTH) : r_s1_shift;
  assign w_rnd = (w_s != '0) ? (RW'(1) << (w_s - 1'b1)) : '0;
  assign w_ext = {r_s1_sum[SW-1], r_s1_sum};
  assign w_add = w_ext + $signed(w_rnd);
  assign w_r   = w_add >>> w_s;

`ifdef PE_REQUANT_RELU_EN
  assign w_clip = (r_s2_r < 0) ? '0 : r_s2_r;
`else
  assign w_clip = r_s2_r;
`endif

  assign w_sat = (w_clip > LMAX) ? OUT_WIDTH'(LMAX)
               : (w_clip < LMIN) ? OUT_WIDTH'(LMIN)
               : w_clip[OUT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bias     <= '0;
      r_shift    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_shift <= '0;
      r_s2_valid <= 1'b0;
      r_s2_r     <= '0;
      r_s3_valid <= 1'b0;
      r_s3_data  <= '0;
    end else begin
      if (cfg_load) begin
        r_bias  <= bias_in;
        r_shift <= shift_in;
      end
      r_s1_valid <= acc_valid;
      r_s1_sum   <= w_sum;
      r_s1_shift <= r_shift;
      r_s2_valid <= r_s1_valid;
      r_s2_r     <= w_r;
      r_s3_valid <= r_s2_valid;
      r_s3_data  <= w_sat;
    end
  end

  logic [OUT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr;
  logic [AW-1:0]        r_rd;
  logic [CW-1:0]        r_cnt;
  logic [OUT_WIDTH-1:0] r_last;
  logic                 r_drop;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full = (r_cnt == CW'(FIFO_DEPTH));
  assign w_pop  = out_valid & out_ready;
  // When full, a same-edge pop frees the slot the push lands in.
  assign w_push = r_s3_valid & (~w_full | w_pop);
  assign w_drop = r_s3_valid & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_last <= '0;
      r_drop <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) begin
        r_rd   <= r_rd + AW'(1);
        r_last <= r_mem[r_rd];
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_drop) r_drop <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= r_s3_data;
  end

  assign out_valid  = (r_cnt != '0);
  assign out_data   = out_valid ? r_mem[r_rd] : r_last;
  assign fifo_count = r_cnt;
  assign drop_err   = r_drop;

endmodule

// File: tb/tb_pe_requant.sv
// Scoreboard bench for pe_requant: directed vectors, expected bytes queued
// at issue time and checked by an independent output monitor.
module tb_pe_requant;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_load;
  logic [15:0] bias_in;
  logic [4:0]  shift_in;
  logic        acc_valid;
  logic [23:0] pe_y;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  fifo_count;
  logic        drop_err;

  int total = 0;
  int bad = 0;
  logic [7:0] q[$];

`ifdef PE_REQUANT_RELU_EN
  localparam logic [7:0] E_M75 = 8'h00;
  localparam logic [7:0] E_M1  = 8'h00;
  localparam logic [7:0] E_SATN = 8'h00;
`else
  localparam logic [7:0] E_M75 = 8'hB5;
  localparam logic [7:0] E_M1  = 8'hFF;
  localparam logic [7:0] E_SATN = 8'h80;
`endif

  pe_requant dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load),
    .bias_in(bias_in), .shift_in(shift_in),
    .acc_valid(acc_valid), .pe_y(pe_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .fifo_count(fifo_count),
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0h want none", out_data);
      end else begin
        check("sb_data", {24'd0, out_data}, {24'd0, q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int b, input int s);
    cfg_load = 1'b1;
    bias_in  = 16'(b);
    shift_in = 5'(s);
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic send(input int y, input logic [7:0] e, input bit keep);
    pe_y      = 24'(y);
    acc_valid = 1'b1;
    if (keep) q.push_back(e);
    tick();
    acc_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    cfg_load = 1'b0;
    bias_in = '0;
    shift_in = '0;
    acc_valid = 1'b0;
    pe_y = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_drop", drop_err, 0);
    check("rst_data", out_data, 0);
    reset = 1'b1;
    tick();

    // 1: saturation and latency
    cfg(24, 3);
    send(1000, 8'h7F, 1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("lat_e2", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_e3", out_valid, 1);
    tick();
    wait_drain();

    // 2,3: negative, rounding, shift clamp
    cfg(0, 2);
    send(-300, E_M75, 1);
    send(6, 8'h02, 1);
    send(-6, E_M1, 1);
    cfg(0, 0);
    send(100, 8'h64, 1);
    send(-1000, E_SATN, 1);
    cfg(0, 31);
    send(-1, 8'h00, 1);
    wait_drain();

    // full FIFO with same-edge push and pop
    cfg(0, 0);
    out_ready = 1'b0;
    send(10, 8'd10, 1);
    send(20, 8'd20, 1);
    send(30, 8'd30, 1);
    send(40, 8'd40, 1);
    repeat (4) tick();
    check("full_count", fifo_count, 4);
    send(50, 8'd50, 1);
    tick();
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("pp_count", fifo_count, 4);
    check("pp_drop", drop_err, 0);
    tick();
    wait_drain();

    // 4: overflow drops the 5th sample
    out_ready = 1'b0;
    send(1, 8'd1, 1);
    send(2, 8'd2, 1);
    send(3, 8'd3, 1);
    send(4, 8'd4, 1);
    send(5, 8'd5, 0);
    repeat (5) tick();
    check("ovf_count", fifo_count, 4);
    check("ovf_drop", drop_err, 1);
    check("ovf_head", out_data, 1);
    tick();
    check("ovf_hold", out_data, 1);
    out_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    check("emp_valid", out_valid, 0);
    check("emp_last", out_data, 4);
    check("drop_sticky", drop_err, 1);
    tick();

    // 5: config change coincident with a sample
    cfg_load  = 1'b1;
    bias_in   = 16'd50;
    shift_in  = 5'd0;
    pe_y      = 24'd10;
    acc_valid = 1'b1;
    q.push_back(8'd10);
    tick();
    cfg_load  = 1'b0;
    acc_valid = 1'b0;
    send(10, 8'd60, 1);
    wait_drain();

    // 6: reset aborts queued and in-flight data
    cfg(0, 0);
    out_ready = 1'b0;
    send(1, 8'd1, 1);
    send(2, 8'd2, 1);
    repeat (3) tick();
    check("pre_rst_count", fifo_count, 2);
    send(3, 8'd3, 1);
    reset = 1'b0;
    q.delete();
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("r6_valid", out_valid, 0);
    check("r6_count", fifo_count, 0);
    check("r6_drop", drop_err, 0);
    check("r6_data", out_data, 0);
    tick();
    out_ready = 1'b1;
    repeat (8) tick();
    check("r6_idle", fifo_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
